// File: rtl/i2c_codec_pkg.sv
// Shared definitions for the CODEC control-port I2C responder: device constants,
// FSM state encoding and the register-write byte packing helper.
package i2c_codec_pkg;

  localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;
  localparam int         CODEC_NUM_REGS = 19;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_BYTE,
    ST_REG_ACK,
    ST_DATA_BYTE,
    ST_DATA_ACK,
    ST_TX_BYTE,
    ST_TX_ACK_WAIT,
    ST_IGNORE
  } state_e;

  // {byte0, byte1} for a register write: byte0 = {addr, d[8]}, byte1 = d[7:0].
  function automatic logic [15:0] pack_reg_write(input logic [6:0] addr, input logic [8:0] d);
    return {addr, d};
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes one SCL/SDA pin pair and produces registered SCL edge,
// START and STOP pulses plus the SDA level aligned with those pulses.
module i2c_line_sync (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // bits [1:0] form the synchronizer, bit [2] is the edge-detect history
  logic [2:0] r_scl;
  logic [2:0] r_sda;
  logic       r_scl_rise;
  logic       r_scl_fall;
  logic       r_start;
  logic       r_stop;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_scl      <= 3'b111;
      r_sda      <= 3'b111;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl      <= {r_scl[1:0], i_scl};
      r_sda      <= {r_sda[1:0], i_sda};
      r_scl_rise <= r_scl[1] & ~r_scl[2];
      r_scl_fall <= ~r_scl[1] & r_scl[2];
      r_start    <= r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
      r_stop     <= r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];
    end
  end

  assign o_sda      = r_sda[2];
  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;

endmodule

// File: rtl/i2c_codec_reg_responder.sv
// I2C target model of the audio CODEC control port: 7-bit address / 9-bit data
// register writes, 8-bit register reads, and a register file with a debug port.
module i2c_codec_reg_responder
  import i2c_codec_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = CODEC_DEV_ADDR,
  parameter int         NUM_REGS = CODEC_NUM_REGS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i2c_scl_i,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  output logic       reg_wr_strobe,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  output logic       addr_err,
  output logic       busy,
  input  logic [6:0] dbg_addr,
  output logic [8:0] dbg_data
);

  localparam logic [7:0] LP_NREGS = 8'(NUM_REGS);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_line_sync u_line_sync (
    .clk        (clk),
    .i_rst_n    (reset_n),
    .i_scl      (i2c_scl_i),
    .i_sda      (i2c_sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_e     r_state;
  logic [3:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [7:0] r_tx;
  logic [6:0] r_addr;
  logic       r_d8, r_rw, r_sda_t, r_busy, r_wr_strobe, r_addr_err;
  logic [6:0] r_wr_addr;
  logic [8:0] r_wr_data;
  logic [8:0] r_regs [NUM_REGS];

  logic [7:0] w_rd_byte;
  logic       w_byte_done;
  logic       w_reg_in_range;

  // Read mux for the transmit byte and the debug port; out-of-range reads give 0.
  always_comb begin
    w_rd_byte = 8'h00;
    dbg_data  = 9'h000;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_addr == 7'(i))   w_rd_byte = r_regs[i][7:0];
      if (dbg_addr == 7'(i)) dbg_data  = r_regs[i];
    end
  end

  assign w_byte_done    = w_scl_fall && (r_bitcnt == 4'd8);
  assign w_reg_in_range = {1'b0, r_shift[7:1]} < LP_NREGS;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= 4'd0;
      r_shift     <= 8'h00;
      r_tx        <= 8'h00;
      r_addr      <= 7'd0;
      r_d8        <= 1'b0;
      r_rw        <= 1'b0;
      r_sda_t     <= 1'b1;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_addr_err  <= 1'b0;
      r_wr_addr   <= 7'd0;
      r_wr_data   <= 9'h000;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 9'h000;
    end else begin
      r_wr_strobe <= 1'b0;
      r_addr_err  <= 1'b0;
      if (w_stop) begin
        r_state <= ST_IDLE;
        r_sda_t <= 1'b1;
        r_busy  <= 1'b0;
        r_addr  <= 7'd0;
      end else if (w_start) begin
        // a repeated START keeps the latched register address for the read phase
        r_state  <= ST_DEV_ADDR;
        r_bitcnt <= 4'd0;
        r_sda_t  <= 1'b1;
        r_busy   <= 1'b1;
        if (!r_busy) r_addr <= 7'd0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_DEV_ADDR, ST_REG_BYTE, ST_DATA_BYTE, ST_TX_BYTE: begin
            r_shift  <= {r_shift[6:0], w_sda};
            r_bitcnt <= r_bitcnt + 4'd1;
          end
          ST_TX_ACK_WAIT: if (w_sda) r_state <= ST_IGNORE;
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          ST_DEV_ADDR: if (w_byte_done) begin
            if (r_shift[7:1] == DEV_ADDR) begin
              r_rw    <= r_shift[0];
              r_sda_t <= 1'b0;
              r_state <= ST_DEV_ACK;
            end else begin
              r_state <= ST_IGNORE;
            end
          end
          ST_DEV_ACK: begin
            r_bitcnt <= 4'd0;
            if (r_rw) begin
              r_tx    <= w_rd_byte;
              r_sda_t <= w_rd_byte[7];
              r_state <= ST_TX_BYTE;
            end else begin
              r_sda_t <= 1'b1;
              r_state <= ST_REG_BYTE;
            end
          end
          ST_REG_BYTE: if (w_byte_done) begin
            if (w_reg_in_range) begin
              r_addr  <= r_shift[7:1];
              r_d8    <= r_shift[0];
              r_sda_t <= 1'b0;
              r_state <= ST_REG_ACK;
            end else begin
              r_addr_err <= 1'b1;
              r_state    <= ST_IGNORE;
            end
          end
          ST_REG_ACK: begin
            r_bitcnt <= 4'd0;
            r_sda_t  <= 1'b1;
            r_state  <= ST_DATA_BYTE;
          end
          ST_DATA_BYTE: if (w_byte_done) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (r_addr == 7'(i)) r_regs[i] <= {r_d8, r_shift};
            r_wr_strobe <= 1'b1;
            r_wr_addr   <= r_addr;
            r_wr_data   <= {r_d8, r_shift};
            r_sda_t     <= 1'b0;
            r_state     <= ST_DATA_ACK;
          end
          ST_DATA_ACK: begin
            r_sda_t <= 1'b1;
            r_state <= ST_IGNORE;
          end
          ST_TX_BYTE: begin
            if (r_bitcnt == 4'd8) begin
              r_sda_t <= 1'b1;
              r_state <= ST_TX_ACK_WAIT;
            end else begin
              r_tx    <= {r_tx[6:0], 1'b0};
              r_sda_t <= r_tx[6];
            end
          end
          ST_TX_ACK_WAIT: begin
            // master ACKed: resend the same register byte
            r_bitcnt <= 4'd0;
            r_tx     <= w_rd_byte;
            r_sda_t  <= w_rd_byte[7];
            r_state  <= ST_TX_BYTE;
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sda_o     = 1'b0;
  assign i2c_sda_t     = r_sda_t;
  assign reg_wr_strobe = r_wr_strobe;
  assign reg_wr_addr   = r_wr_addr;
  assign reg_wr_data   = r_wr_data;
  assign addr_err      = r_addr_err;
  assign busy          = r_busy;

endmodule

// File: tb/tb_i2c_codec_reg_responder.sv
// Bench for the CODEC I2C register responder: a bit-banged I2C master, a
// vector table, hand-written corner sequences and randomized traffic vs a model.
module tb_i2c_codec_reg_responder;

  logic       clk;
  logic       reset_n;
  logic       m_scl, m_sda;
  logic       i2c_scl_i, i2c_sda_i, i2c_sda_o, i2c_sda_t;
  logic       reg_wr_strobe, addr_err, busy;
  logic [6:0] reg_wr_addr, dbg_addr;
  logic [8:0] reg_wr_data, dbg_data;

  // open-drain bus: the responder can only pull the master's level low
  assign i2c_scl_i = m_scl;
  assign i2c_sda_i = m_sda & i2c_sda_t;

  i2c_codec_reg_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i2c_scl_i     (i2c_scl_i),
    .i2c_sda_i     (i2c_sda_i),
    .i2c_sda_o     (i2c_sda_o),
    .i2c_sda_t     (i2c_sda_t),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data),
    .addr_err      (addr_err),
    .busy          (busy),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int pulse_bad = 0;
  logic prev_stb = 1'b0;
  logic prev_err = 1'b0;
  logic [8:0] mregs [0:127];

  // Pulse monitor: counts strobes/errors, flags multi-cycle pulses and wrong SDA alignment.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (reg_wr_strobe === 1'b1) begin
        stb_cnt++;
        if (prev_stb || i2c_sda_t !== 1'b0) pulse_bad++;
      end
      if (addr_err === 1'b1) begin
        err_cnt++;
        if (prev_err || i2c_sda_t !== 1'b1) pulse_bad++;
      end
    end
    prev_stb = (reg_wr_strobe === 1'b1);
    prev_err = (addr_err === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mbit(input logic b);
    m_sda = b; wait_clk(5); m_scl = 1'b1; wait_clk(10); m_scl = 1'b0; wait_clk(5);
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; wait_clk(5); m_scl = 1'b1; wait_clk(9);
    b = i2c_sda_i; wait_clk(1); m_scl = 1'b0; wait_clk(5);
  endtask

  task automatic do_start();
    m_sda = 1'b1;
    wait_clk(5);
    if (m_scl == 1'b0) begin m_scl = 1'b1; wait_clk(10); end
    m_sda = 1'b0; wait_clk(10); m_scl = 1'b0; wait_clk(5);
  endtask

  task automatic do_stop();
    m_sda = 1'b0; wait_clk(5); m_scl = 1'b1; wait_clk(10); m_sda = 1'b1; wait_clk(10);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic [7:0] s;
    s = d;
    repeat (8) begin mbit(s[7]); s = {s[6:0], 1'b0}; end
    rbit(ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    repeat (8) begin rbit(b); d = {d[6:0], b}; end
    mbit(mack);
  endtask

  task automatic write_txn(input logic [7:0] dev, input logic [7:0] b0, input logic [7:0] b1,
                           input logic extra, output logic [2:0] acks, output logic ax);
    logic a;
    do_start();
    wbyte(dev, a); acks[2] = a;
    wbyte(b0, a);  acks[1] = a;
    wbyte(b1, a);  acks[0] = a;
    ax = 1'b1;
    if (extra) wbyte(8'h5A, ax);
    do_stop();
  endtask

  // Model of a write: device must be 0x1A/W and the register index below 19.
  task automatic model_write(input logic [7:0] dev, input logic [7:0] b0, input logic [7:0] b1,
                             output logic [2:0] acks, output int stb, output int err);
    logic dm, inr;
    dm = (dev == 8'h34);
    inr = (b0[7:1] < 7'd19);
    acks = {!dm, !(dm && inr), !(dm && inr)};
    stb = (dm && inr) ? 1 : 0;
    err = (dm && !inr) ? 1 : 0;
    if (dm && inr) mregs[b0[7:1]] = {b0[0], b1};
  endtask

  function automatic logic [8:0] model_dbg(input logic [6:0] a);
    return (a < 7'd19) ? mregs[a] : 9'h000;
  endfunction

  task automatic chk_dbg(input string nm, input logic [6:0] a, input logic [8:0] exp);
    dbg_addr = a; #1;
    check(nm, dbg_data, exp);
  endtask

  typedef struct {
    logic [7:0] dev, b0, b1;
    logic [2:0] exp_ack;
    int         exp_stb, exp_err;
    logic [6:0] exp_wa;
    logic [8:0] exp_wd;
    logic [6:0] dbg;
    logic [8:0] exp_dbg;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [2:0] acks, macks;
    logic       ax, a;
    logic [7:0] d;
    logic [6:0] ra;
    logic [8:0] rd;
    int s0, e0, mstb, merr, bad, nb;

    vecs[0] = '{dev:8'h34, b0:8'h0F, b1:8'hA5, exp_ack:3'b000, exp_stb:1, exp_err:0, exp_wa:7'h07, exp_wd:9'h1A5, dbg:7'h07, exp_dbg:9'h1A5};
    vecs[1] = '{dev:8'h36, b0:8'h0F, b1:8'h11, exp_ack:3'b111, exp_stb:0, exp_err:0, exp_wa:7'h07, exp_wd:9'h1A5, dbg:7'h07, exp_dbg:9'h1A5};
    vecs[2] = '{dev:8'h34, b0:8'h60, b1:8'h55, exp_ack:3'b011, exp_stb:0, exp_err:1, exp_wa:7'h07, exp_wd:9'h1A5, dbg:7'h07, exp_dbg:9'h1A5};
    vecs[3] = '{dev:8'h34, b0:8'h25, b1:8'h3C, exp_ack:3'b000, exp_stb:1, exp_err:0, exp_wa:7'h12, exp_wd:9'h13C, dbg:7'h12, exp_dbg:9'h13C};
    vecs[4] = '{dev:8'h34, b0:8'h26, b1:8'h11, exp_ack:3'b011, exp_stb:0, exp_err:1, exp_wa:7'h12, exp_wd:9'h13C, dbg:7'h13, exp_dbg:9'h000};
    vecs[5] = '{dev:8'h34, b0:8'h00, b1:8'hFF, exp_ack:3'b000, exp_stb:1, exp_err:0, exp_wa:7'h00, exp_wd:9'h0FF, dbg:7'h00, exp_dbg:9'h0FF};

    for (int i = 0; i < 128; i++) mregs[i] = 9'h000;
    m_scl = 1'b1; m_sda = 1'b1; reset_n = 1'b0; dbg_addr = 7'h00;
    wait_clk(5);
    check("rst_sda_t", i2c_sda_t, 1'b1);
    check("rst_sda_o", i2c_sda_o, 1'b0);
    check("rst_strobe", reg_wr_strobe, 1'b0);
    check("rst_wr_addr", reg_wr_addr, 7'h00);
    check("rst_wr_data", reg_wr_data, 9'h000);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    wait_clk(10);

    // Vector table of complete write transactions
    for (int i = 0; i < 6; i++) begin
      s0 = stb_cnt; e0 = err_cnt;
      write_txn(vecs[i].dev, vecs[i].b0, vecs[i].b1, 1'b0, acks, ax);
      model_write(vecs[i].dev, vecs[i].b0, vecs[i].b1, macks, mstb, merr);
      check($sformatf("vec%0d_acks", i), acks, vecs[i].exp_ack);
      check($sformatf("vec%0d_strobes", i), stb_cnt - s0, vecs[i].exp_stb);
      check($sformatf("vec%0d_addr_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_wr_addr", i), reg_wr_addr, vecs[i].exp_wa);
      check($sformatf("vec%0d_wr_data", i), reg_wr_data, vecs[i].exp_wd);
      check($sformatf("vec%0d_busy", i), busy, 1'b0);
      chk_dbg($sformatf("vec%0d_dbg", i), vecs[i].dbg, vecs[i].exp_dbg);
    end

    // Read reg 0x07 via repeated START, master ACKs once then NACKs
    do_start();
    check("rd_busy_on", busy, 1'b1);
    wbyte(8'h34, a); check("rd_dev_w_ack", a, 1'b0);
    wbyte(8'h0E, a); check("rd_reg_ack", a, 1'b0);
    do_start();
    wbyte(8'h35, a); check("rd_dev_r_ack", a, 1'b0);
    rbyte(1'b0, d);  check("rd_byte0", d, 8'hA5);
    rbyte(1'b1, d);  check("rd_byte1_resend", d, 8'hA5);
    do_stop();
    check("rd_busy_off", busy, 1'b0);
    check("rd_sda_released", i2c_sda_t, 1'b1);

    // Partial write (STOP after byte0) must not commit
    write_txn(8'h34, 8'h08, 8'h77, 1'b0, acks, ax);
    model_write(8'h34, 8'h08, 8'h77, macks, mstb, merr);
    s0 = stb_cnt;
    do_start();
    wbyte(8'h34, a);
    wbyte(8'h09, a); check("part_reg_ack", a, 1'b0);
    do_stop();
    check("part_no_strobe", stb_cnt - s0, 0);
    chk_dbg("part_reg4_kept", 7'h04, 9'h077);
    write_txn(8'h34, 8'h09, 8'hC3, 1'b1, acks, ax);
    model_write(8'h34, 8'h09, 8'hC3, macks, mstb, merr);
    check("part_next_acks", acks, 3'b000);
    check("extra_byte_nack", ax, 1'b1);
    chk_dbg("part_next_reg4", 7'h04, 9'h1C3);

    // Reset while the responder drives the device-address ACK
    do_start();
    d = 8'h34;
    repeat (8) begin mbit(d[7]); d = {d[6:0], 1'b0}; end
    m_sda = 1'b1;
    wait_clk(6);
    check("rst_mid_ack_driven", i2c_sda_t, 1'b0);
    reset_n = 1'b0;
    wait_clk(1);
    check("rst_mid_sda_released", i2c_sda_t, 1'b1);
    m_scl = 1'b1;
    wait_clk(5);
    reset_n = 1'b1;
    wait_clk(10);
    for (int i = 0; i < 128; i++) mregs[i] = 9'h000;
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      dbg_addr = 7'(i); #1;
      if (dbg_data !== 9'h000) bad++;
    end
    check("rst_regs_cleared", bad, 0);
    check("rst_busy_clear", busy, 1'b0);
    write_txn(8'h34, 8'h0F, 8'hA5, 1'b0, acks, ax);
    model_write(8'h34, 8'h0F, 8'hA5, macks, mstb, merr);
    check("post_rst_acks", acks, 3'b000);
    chk_dbg("post_rst_dbg", 7'h07, 9'h1A5);

    // Randomized writes and reads against the reference model
    for (int t = 0; t < 24; t++) begin
      ra = 7'($urandom_range(0, 23));
      rd = 9'($urandom_range(0, 511));
      s0 = stb_cnt; e0 = err_cnt;
      if ($urandom_range(0, 2) != 0) begin
        d = ($urandom_range(0, 5) == 0) ? 8'h36 : 8'h34;
        ax = ($urandom_range(0, 3) == 0);
        write_txn(d, {ra, rd[8]}, rd[7:0], ax, acks, a);
        model_write(d, {ra, rd[8]}, rd[7:0], macks, mstb, merr);
        check($sformatf("rnd%0d_w_acks", t), acks, macks);
        if (ax) check($sformatf("rnd%0d_w_extra", t), a, 1'b1);
        check($sformatf("rnd%0d_w_strobes", t), stb_cnt - s0, mstb);
        check($sformatf("rnd%0d_w_err", t), err_cnt - e0, merr);
        if (mstb == 1) begin
          check($sformatf("rnd%0d_w_addr", t), reg_wr_addr, ra);
          check($sformatf("rnd%0d_w_data", t), reg_wr_data, rd);
        end
        chk_dbg($sformatf("rnd%0d_w_dbg", t), ra, model_dbg(ra));
      end else begin
        nb = $urandom_range(1, 2);
        do_start();
        wbyte(8'h34, a);
        wbyte({ra, 1'b0}, a);
        check($sformatf("rnd%0d_r_regack", t), a, (ra < 7'd19) ? 1'b0 : 1'b1);
        do_start();
        wbyte(8'h35, a);
        check($sformatf("rnd%0d_r_devack", t), a, 1'b0);
        for (int k = 0; k < nb; k++) begin
          rbyte((k == nb - 1), d);
          check($sformatf("rnd%0d_r_data%0d", t, k), d,
                (ra < 7'd19) ? mregs[ra][7:0] : mregs[0][7:0]);
        end
        do_stop();
        check($sformatf("rnd%0d_r_err", t), err_cnt - e0, (ra < 7'd19) ? 0 : 1);
        check($sformatf("rnd%0d_r_nostrobe", t), stb_cnt - s0, 0);
      end
    end

    check("pulse_shape", pulse_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
